// File: rtl/bsg_rf_2r1w_sync_ctrl.sv
// bsg_rf_2r1w_sync_ctrl: zero-fills a 2r1w sync register file, then serves x0, bypass and hold around it
module bsg_rf_2r1w_sync_ctrl #(
  parameter int width_p = 32,
  parameter int els_p = 32,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  output logic                     ready_o,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r0_v_i,
  input  logic [addr_width_lp-1:0] r0_addr_i,
  input  logic                     r1_v_i,
  input  logic [addr_width_lp-1:0] r1_addr_i,
  output logic [width_p-1:0]       r0_data_o,
  output logic [width_p-1:0]       r1_data_o,
  output logic                     mem_w_v_o,
  output logic [addr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0]       mem_w_data_o,
  output logic                     mem_r0_v_o,
  output logic [addr_width_lp-1:0] mem_r0_addr_o,
  output logic                     mem_r1_v_o,
  output logic [addr_width_lp-1:0] mem_r1_addr_o,
  input  logic [width_p-1:0]       mem_r0_data_i,
  input  logic [width_p-1:0]       mem_r1_data_i
);
  localparam logic [addr_width_lp:0]   els_lp  = (addr_width_lp+1)'(els_p);
  localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_e;
  typedef enum logic [1:0] {HOLD, ZERO, BYP, MEM} sel_e;
  state_e state, state_n;
  logic [addr_width_lp-1:0] cnt, cnt_n;
  logic run, w_ok;
  logic [1:0] rv, mv;
  logic [addr_width_lp-1:0] ra [2];
  logic [width_p-1:0] md [2];
  logic [width_p-1:0] rd [2];
  assign run  = state == RUN;
  assign w_ok = w_v_i && w_addr_i != '0 && {1'b0, w_addr_i} < els_lp;
  always_comb begin
    state_n = state == IDLE ? INIT : (state == INIT && cnt == last_lp) ? RUN : state;
    cnt_n   = state == INIT ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_o <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_o <= state_n == RUN;
    end
  assign mem_w_v_o     = state == INIT || (run && w_ok);
  assign mem_w_addr_o  = state == INIT ? cnt : w_addr_i;
  assign mem_w_data_o  = state == INIT ? '0 : w_data_i;
  assign rv            = {r1_v_i, r0_v_i};
  assign ra[0]         = r0_addr_i;
  assign ra[1]         = r1_addr_i;
  assign md[0]         = mem_r0_data_i;
  assign md[1]         = mem_r1_data_i;
  assign mem_r0_v_o    = mv[0];
  assign mem_r1_v_o    = mv[1];
  assign mem_r0_addr_o = r0_addr_i;
  assign mem_r1_addr_o = r1_addr_i;
  assign r0_data_o     = rd[0];
  assign r1_data_o     = rd[1];
  for (genvar p = 0; p < 2; p++) begin : port
    sel_e sel_n, sel_q;
    logic in_rng;
    logic [width_p-1:0] byp, last;
    assign in_rng = ra[p] != '0 && {1'b0, ra[p]} < els_lp;
    // a colliding read never reaches the memory; it takes the write data instead
    always_comb sel_n = !run ? ZERO : !rv[p] ? HOLD : !in_rng ? ZERO : (w_ok && w_addr_i == ra[p]) ? BYP : MEM;
    assign mv[p] = sel_n == MEM;
    assign rd[p] = sel_q == MEM ? md[p] : sel_q == BYP ? byp : sel_q == ZERO ? '0 : last;
    always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
        sel_q <= ZERO;
        byp   <= '0;
        last  <= '0;
      end else begin
        sel_q <= sel_n;
        if (sel_n == BYP) byp <= w_data_i;
        last  <= rd[p];
      end
  end
endmodule

// File: tb/tb_bsg_rf_2r1w_sync_ctrl.sv
// tb_bsg_rf_2r1w_sync_ctrl: scoreboard bench with a behavioral 2r1w sync memory behind the controller
module tb_bsg_rf_2r1w_sync_ctrl;
  logic clk, reset_n_i, ready_o;
  logic w_v_i, r0_v_i, r1_v_i;
  logic [4:0] w_addr_i, r0_addr_i, r1_addr_i;
  logic [31:0] w_data_i, r0_data_o, r1_data_o;
  logic mem_w_v_o, mem_r0_v_o, mem_r1_v_o;
  logic [4:0] mem_w_addr_o, mem_r0_addr_o, mem_r1_addr_o;
  logic [31:0] mem_w_data_o, mem_r0_data_i, mem_r1_data_i;
  logic [31:0] mem [32];
  logic [31:0] rf [32];
  logic [31:0] last0, last1;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int checks = 0, failures = 0;

  bsg_rf_2r1w_sync_ctrl #(.width_p(32), .els_p(32)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .ready_o(ready_o),
    .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .r0_v_i(r0_v_i), .r0_addr_i(r0_addr_i), .r1_v_i(r1_v_i), .r1_addr_i(r1_addr_i),
    .r0_data_o(r0_data_o), .r1_data_o(r1_data_o),
    .mem_w_v_o(mem_w_v_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
    .mem_r0_v_o(mem_r0_v_o), .mem_r0_addr_o(mem_r0_addr_o),
    .mem_r1_v_o(mem_r1_v_o), .mem_r1_addr_o(mem_r1_addr_o),
    .mem_r0_data_i(mem_r0_data_i), .mem_r1_data_i(mem_r1_data_i)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) mem[i] = 32'hBAD0_0000 + i;
  // unread ports return noise so a hold that leaks memory data is caught
  always @(posedge clk) begin
    if (mem_w_v_o) mem[mem_w_addr_o] <= mem_w_data_o;
    mem_r0_data_i <= mem_r0_v_o ? mem[mem_r0_addr_o] : $urandom;
    mem_r1_data_i <= mem_r1_v_o ? mem[mem_r1_addr_o] : $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model;
    for (int i = 0; i < 32; i++) rf[i] = 0;
    last0 = 0;
    last1 = 0;
  endtask

  // entered just after a posedge with reset low; leaves at a negedge in RUN
  task automatic fill;
    reset_n_i = 1;
    @(negedge clk);
    chk("idle_w_v", mem_w_v_o, 0);
    chk("idle_ready", ready_o, 0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("fill_w_v", mem_w_v_o, 1);
      chk("fill_addr", mem_w_addr_o, k);
      chk("fill_data", mem_w_data_o, 0);
      chk("fill_ready", ready_o, 0);
      chk("fill_r_v", {mem_r0_v_o, mem_r1_v_o}, 0);
    end
    @(negedge clk);
    chk("run_ready", ready_o, 1);
    chk("run_w_v", mem_w_v_o, 0);
    clear_model;
  endtask

  // driven at a negedge; returns at the next negedge
  task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input logic v0, input logic [4:0] a0, input logic v1, input logic [4:0] a1);
    logic wacc;
    logic [31:0] e0, e1;
    w_v_i = wv; w_addr_i = wa; w_data_i = wd;
    r0_v_i = v0; r0_addr_i = a0; r1_v_i = v1; r1_addr_i = a1;
    wacc = wv && wa != 0;
    e0 = !v0 ? last0 : a0 == 0 ? 0 : (wacc && wa == a0) ? wd : rf[a0];
    e1 = !v1 ? last1 : a1 == 0 ? 0 : (wacc && wa == a1) ? wd : rf[a1];
    last0 = e0;
    last1 = e1;
    q0.push_back(e0);
    q1.push_back(e1);
    #1;
    chk("mem_w_v", mem_w_v_o, wacc);
    chk("mem_r0_v", mem_r0_v_o, v0 && a0 != 0 && !(wacc && wa == a0));
    chk("mem_r1_v", mem_r1_v_o, v1 && a1 != 0 && !(wacc && wa == a1));
    chk("no_collide", (mem_w_v_o && mem_r0_v_o && mem_w_addr_o == mem_r0_addr_o) ||
                      (mem_w_v_o && mem_r1_v_o && mem_w_addr_o == mem_r1_addr_o), 0);
    if (wacc) rf[wa] = wd;
    @(posedge clk);
    #1;
    chk("r0_data", r0_data_o, q0.pop_front());
    chk("r1_data", r1_data_o, q1.pop_front());
    @(negedge clk);
  endtask

  initial begin
    reset_n_i = 0;
    w_v_i = 0; w_addr_i = 0; w_data_i = 0;
    r0_v_i = 0; r0_addr_i = 0; r1_v_i = 0; r1_addr_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_r0", r0_data_o, 0);
    chk("rst_r1", r1_data_o, 0);
    chk("rst_mem_v", {mem_w_v_o, mem_r0_v_o, mem_r1_v_o}, 0);
    fill;
    for (int i = 0; i < 32; i++) step(0, 0, 0, 1, 5'(i), 1, 5'(31 - i));
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0, 0);
    step(1, 7, 32'h12345678, 1, 7, 1, 7);
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(1, 3, 32'hA5A5A5A5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 3, 32'h1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)));
    step(1, 4, 32'hCAFEF00D, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    reset_n_i = 0;
    #1;
    chk("run_rst_ready", ready_o, 0);
    chk("run_rst_r0", r0_data_o, 0);
    chk("run_rst_mem_v", {mem_w_v_o, mem_r0_v_o, mem_r1_v_o}, 0);
    @(posedge clk);
    #1;
    reset_n_i = 1;
    for (int i = 0; i < 40 && !(mem_w_v_o && mem_w_addr_o == 10); i++) @(negedge clk);
    chk("cnt10_reached", {mem_w_v_o, 26'd0, mem_w_addr_o}, {1'b1, 26'd0, 5'd10});
    reset_n_i = 0;
    #1;
    chk("init_rst_ready", ready_o, 0);
    chk("init_rst_w_v", mem_w_v_o, 0);
    chk("init_rst_r", r0_data_o | r1_data_o, 0);
    @(posedge clk);
    #1;
    fill;
    for (int i = 0; i < 32; i++) step(0, 0, 0, 1, 5'(i), 1, 5'(i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bsg_rf_2r1w_sync_ctrl.md
# bsg_rf_2r1w_sync_ctrl

Controller between the RV32I pipeline's decode/writeback stages and a `bsg_mem_2r1w_sync` register-file instance configured with `read_write_same_addr_p=0`. After reset it zero-fills the storage, since the synchronous memory has no reset. It then hard-wires x0 to zero and bypasses same-cycle write data to colliding reads, so the memory never sees a same-address read/write. It also holds read data stable when no read was issued.

## Interface
- width_p, 32, data width
- els_p, 32, number of registers (need not be a power of two)
- addr_width_lp, `BSG_SAFE_CLOG2(els_p)`, address width (derived)

- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- ready_o  out  1  zero-fill done; pipeline may issue accesses
- w_v_i / w_addr_i / w_data_i  in  1 / addr_width_lp / width_p  writeback request
- r0_v_i / r0_addr_i  in  1 / addr_width_lp  read port 0 request
- r1_v_i / r1_addr_i  in  1 / addr_width_lp  read port 1 request
- r0_data_o / r1_data_o  out  width_p  read data, valid the cycle after the request
- mem_w_v_o / mem_w_addr_o / mem_w_data_o  out  1 / addr_width_lp / width_p  memory write port
- mem_r0_v_o / mem_r0_addr_o  out  1 / addr_width_lp  memory read port 0
- mem_r1_v_o / mem_r1_addr_o  out  1 / addr_width_lp  memory read port 1
- mem_r0_data_i / mem_r1_data_i  in  width_p  memory read data, one cycle after the request

## Operation
- FSM states: IDLE (reset state), INIT, RUN.
- IDLE
  - All mem_*_v_o = 0; ready_o = 0.
  - The first clk_i rising edge after reset_n_i deasserts moves to INIT with cnt = 0.
- INIT
  - Drives mem_w_v_o = 1, mem_w_addr_o = cnt, mem_w_data_o = 0; cnt increments each cycle.
  - When cnt == els_p-1, the write is issued and the FSM moves to RUN.
  - Read valids are 0. Pipeline requests are ignored: writes are dropped, reads select ZERO.
- RUN, write path
  - mem_w_v_o = w_v_i && w_addr_i != 0 && w_addr_i < els_p; mem_w_addr_o and mem_w_data_o pass through.
  - Writes to x0 or to out-of-range addresses are dropped.
- RUN, each read port p, in priority order, registered as sel_p for the next cycle:
  - !rp_v_i -> HOLD; mem_rp_v_o = 0.
  - rp_addr_i == 0 or rp_addr_i >= els_p -> ZERO; mem_rp_v_o = 0.
  - w_v_i && w_addr_i == rp_addr_i (write accepted per the write rule) -> BYP; mem_rp_v_o = 0; w_data_i captured into byp_p.
  - Otherwise -> MEM; mem_rp_v_o = 1, mem_rp_addr_o = rp_addr_i.
- Output mux, combinational from sel_p:
  - MEM -> mem_rp_data_i
  - BYP -> byp_p
  - ZERO -> 0
  - HOLD -> last_p
- last_p captures rp_data_o every cycle.
- Both ports may bypass the same write simultaneously. Each port has its own byp register.
- Invariant: the controller never asserts mem_w_v_o and mem_rp_v_o to the same address in the same cycle.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, ready_o = 0
  - sel_0 = sel_1 = ZERO, so r*_data_o = 0
  - byp_* = 0, last_* = 0
  - all mem_*_v_o = 0
- ready_o is registered. It rises on the edge that enters RUN, i.e. els_p+1 edges after reset release.
- Read latency is 1 cycle. A request in cycle N yields data in cycle N+1, from any source.
- A write in cycle N is visible to a read issued in cycle N (via bypass) and to reads issued in cycle N+1 and later (via memory).
- Reset asserted at any point asynchronously returns to IDLE: outputs go to their reset values immediately and any in-progress zero-fill restarts from address 0.
- No backpressure. In RUN every request is accepted every cycle.

## Test plan
- Reset release with els_p=32 -> mem_w_v_o high for exactly 32 cycles, addresses 0..31, data 0; ready_o rises on the 33rd edge; reading any register afterwards returns 0.
- RUN: write x5=0xDEADBEEF in cycle N, read r0=x5 in cycle N+1 -> r0_data_o=0xDEADBEEF in cycle N+2 with mem_r0_v_o=1.
- Same cycle: write x7=0x12345678 while r0=x7 and r1=x7 -> mem_r0_v_o=mem_r1_v_o=0 that cycle; both outputs =0x12345678 next cycle; no same-address assertion fires.
- Write x0=0xFFFFFFFF, then read x0 on both ports -> mem_w_v_o=0; both outputs 0.
- Read x3 (=0xA5A5A5A5), then r0_v_i=0 for 3 cycles while writing x3=0x1 -> r0_data_o stays 0xA5A5A5A5 throughout.
- Assert reset_n_i low mid-INIT (cnt=10) -> ready_o and outputs 0 immediately; after release, fill restarts at address 0 and takes the full 32 cycles.
